imem_loader: RTL and testbench

Boot-time instruction-memory writer for the single-cycle RISC-V `cpu`. It accepts a little-endian byte stream on a valid/ready interface and assembles 32-bit instruction words. It writes the words to sequential instruction-memory word addresses starting at 0, and holds the CPU in reset until the program is loaded. Loading ends on the first `ebreak` word, which is written to memory. The CPU is then released after the same two-cycle reset hold the CPU benches use.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_if.sv | 32 +++
 rtl/imem_loader_word_asm.sv | 31 +++
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Holds the ebreak encoding, loader states and a byte-merge helper.
package imem_loader_pkg;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_RELEASE,
    S_DONE,
    S_FULL
  } state_t;

  function automatic logic [31:0] merge_byte(
    input logic [31:0] w,
    input logic [1:0]  k,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = w;
    r[8*k +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus.
// master = host/memory side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler: byte index counter plus accumulator.
// word is the accumulator with the current byte merged in.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [31:0] acc;

  assign word       = merge_byte(acc, idx, data);
  assign word_valid = en && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx <= 2'd0;
      acc <= '0;
    end else if (en) begin
      idx <= idx + 2'd1;
      acc <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory and holds the CPU in reset
// until the terminating ebreak word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [31:0] HALT_WORD   = EBREAK
) (
  input  logic                clk,
  input  logic                reset,
  imem_loader_if.slave        bus,
  input  logic                reload,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  // HOLD_CYCLES must be at least 1
  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);

  state_t        state;
  logic [HW-1:0] hold;
  logic          take;
  logic          clear;
  logic          word_valid;
  logic [31:0]   word;

  assign bus.in_ready = (state == S_LOAD);
  assign take         = bus.in_valid && bus.in_ready;
  assign clear        = (state == S_DONE) && reload;

  loader_word_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .en         (take),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_LOAD;
      hold          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_loaded  <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (word_valid) begin
            state         <= S_WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= word;
            words_loaded  <= words_loaded + 1'b1;
          end
        end
        S_WRITE: begin
          bus.mem_we <= 1'b0;
          hold       <= '0;
          if (bus.mem_wdata == HALT_WORD) begin
            state <= S_RELEASE;
          end else if (&bus.mem_addr) begin
            // never wrap: park with the CPU still in reset
            state <= S_FULL;
            error <= 1'b1;
          end else begin
            state        <= S_LOAD;
            bus.mem_addr <= bus.mem_addr + 1'b1;
          end
        end
        S_RELEASE: begin
          if (hold == HOLD_LAST) begin
            state     <= S_DONE;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        S_DONE: begin
          if (reload) begin
            state        <= S_LOAD;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            bus.mem_addr <= '0;
            words_loaded <= '0;
          end
        end
        S_FULL: begin
          state <= S_FULL;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: an 8-bit-address instance for
// normal loading and a 2-bit-address instance for overflow.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reload = 1'b0;
  logic reload2 = 1'b0;

  logic       cpu_reset8, done8, error8;
  logic [8:0] wl8;
  logic       cpu_reset2, done2, error2;
  logic [2:0] wl2;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int timeouts = 0;
  int last_wr_cyc = 0;

  logic [39:0] wr8[$];
  logic [39:0] wr2[$];

  imem_loader_if #(.ADDR_WIDTH(8)) bus8();
  imem_loader_if #(.ADDR_WIDTH(2)) bus2();

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_WIDTH(8), .HOLD_CYCLES(2),
    .HALT_WORD(32'h0010_0073)
  ) u_dut8 (
    .clk(clk), .reset(reset), .bus(bus8),
    .reload(reload), .cpu_reset(cpu_reset8),
    .done(done8), .error(error8),
    .words_loaded(wl8)
  );

  imem_loader #(
    .ADDR_WIDTH(2), .HOLD_CYCLES(2),
    .HALT_WORD(32'h0010_0073)
  ) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .reload(reload2), .cpu_reset(cpu_reset2),
    .done(done2), .error(error2),
    .words_loaded(wl2)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus8.mem_we === 1'b1) begin
      wr8.push_back({bus8.mem_addr, bus8.mem_wdata});
      last_wr_cyc = cyc;
    end
    if (bus2.mem_we === 1'b1)
      wr2.push_back({6'd0, bus2.mem_addr, bus2.mem_wdata});
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin bus2.in_valid = 1'b1; bus2.in_data = b; end
    else begin bus8.in_valid = 1'b1; bus8.in_data = b; end
    while (!(sel ? bus2.in_ready : bus8.in_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeouts++;
    @(posedge clk);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(sel, w[8*k +: 8]);
  endtask

  task automatic idle(input bit sel, input int n);
    @(negedge clk);
    if (sel) bus2.in_valid = 1'b0;
    else bus8.in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus8.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    reload = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wr8.delete();
    wr2.delete();
  endtask

  task automatic wait_done8(output bit ok);
    int n;
    n = 0;
    while (done8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (done8 === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_reset8 !== 1'b1) begin fails++;
      $display("FAIL reset_cpu_reset got %b want 1", cpu_reset8); end
    checks++;
    if (done8 !== 1'b0 || error8 !== 1'b0) begin fails++;
      $display("FAIL reset_flags got done=%b err=%b want 0 0", done8, error8); end
    checks++;
    if (wl8 !== 9'd0) begin fails++;
      $display("FAIL reset_words got %0d want 0", wl8); end
    checks++;
    if (bus8.mem_we !== 1'b0 || bus8.mem_addr !== 8'd0) begin fails++;
      $display("FAIL reset_mem got we=%b addr=%h want 0 00", bus8.mem_we, bus8.mem_addr); end
    checks++;
    if (bus8.mem_wdata !== 32'd0) begin fails++;
      $display("FAIL reset_wdata got %h want 0", bus8.mem_wdata); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus8.in_ready !== 1'b1 || cpu_reset8 !== 1'b1) begin fails++;
      $display("FAIL reset_release got rdy=%b rst=%b want 1 1", bus8.in_ready, cpu_reset8); end
  endtask

  task automatic test_basic_load();
    bit ok;
    do_reset();
    send_word(0, 32'h0050_0093);
    send_word(0, 32'h0030_0113);
    send_word(0, 32'h0010_0073);
    idle(0, 1);
    wait_done8(ok);
    checks++;
    if (!ok) begin fails++;
      $display("FAIL basic_done got done=%b want 1", done8); end
    checks++;
    if (wr8.size() !== 3) begin fails++;
      $display("FAIL basic_nwrites got %0d want 3", wr8.size()); end
    else begin
      checks++;
      if (wr8[0] !== {8'd0, 32'h0050_0093}) begin fails++;
        $display("FAIL basic_w0 got %h want 0000500093", wr8[0]); end
      checks++;
      if (wr8[1] !== {8'd1, 32'h0030_0113}) begin fails++;
        $display("FAIL basic_w1 got %h want 0100300113", wr8[1]); end
      checks++;
      if (wr8[2] !== {8'd2, 32'h0010_0073}) begin fails++;
        $display("FAIL basic_w2 got %h want 0200100073", wr8[2]); end
    end
    checks++;
    if (wl8 !== 9'd3) begin fails++;
      $display("FAIL basic_words got %0d want 3", wl8); end
    checks++;
    if (cpu_reset8 !== 1'b0 || (cyc - last_wr_cyc) != 3) begin fails++;
      $display("FAIL basic_release got rst=%b delay=%0d want 0 3",
               cpu_reset8, cyc - last_wr_cyc); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [7:0] prog [12];
    prog = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01,
             8'h30, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) idle(0, $urandom_range(1, 3));
      send_byte(0, prog[i]);
    end
    idle(0, 1);
    wait_done8(ok);
    checks++;
    if (!ok || wr8.size() !== 3) begin fails++;
      $display("FAIL bp_writes got done=%b n=%0d want 1 3", ok, wr8.size()); end
    else begin
      checks++;
      if (wr8[0] !== {8'd0, 32'h0050_0093} ||
          wr8[1] !== {8'd1, 32'h0030_0113} ||
          wr8[2] !== {8'd2, 32'h0010_0073}) begin fails++;
        $display("FAIL bp_data got %h %h %h want 0000500093 0100300113 0200100073",
                 wr8[0], wr8[1], wr8[2]); end
    end
  endtask

  task automatic test_ignored_reload();
    bit ok;
    do_reset();
    send_word(0, 32'h0050_0093);
    send_byte(0, 8'h13);
    send_byte(0, 8'h01);
    idle(0, 1);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    @(negedge clk);
    checks++;
    if (bus8.mem_addr !== 8'd1 || wl8 !== 9'd1) begin fails++;
      $display("FAIL ign_reload_cnt got addr=%0d n=%0d want 1 1", bus8.mem_addr, wl8); end
    checks++;
    if (bus8.in_ready !== 1'b1 || done8 !== 1'b0 || cpu_reset8 !== 1'b1) begin fails++;
      $display("FAIL ign_reload_state got rdy=%b done=%b rst=%b want 1 0 1",
               bus8.in_ready, done8, cpu_reset8); end
    send_byte(0, 8'h30);
    send_byte(0, 8'h00);
    send_word(0, 32'h0010_0073);
    idle(0, 1);
    wait_done8(ok);
    checks++;
    if (!ok || wr8.size() !== 3) begin fails++;
      $display("FAIL ign_reload_writes got done=%b n=%0d want 1 3", ok, wr8.size()); end
    else begin
      checks++;
      if (wr8[1] !== {8'd1, 32'h0030_0113}) begin fails++;
        $display("FAIL ign_reload_w1 got %h want 0100300113", wr8[1]); end
    end
  endtask

  task automatic test_reload();
    bit ok;
    @(negedge clk);
    wr8.delete();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checks++;
    if (cpu_reset8 !== 1'b1 || done8 !== 1'b0) begin fails++;
      $display("FAIL reload_rst got rst=%b done=%b want 1 0", cpu_reset8, done8); end
    checks++;
    if (wl8 !== 9'd0 || bus8.mem_addr !== 8'd0 || bus8.in_ready !== 1'b1) begin fails++;
      $display("FAIL reload_clear got n=%0d addr=%0d rdy=%b want 0 0 1",
               wl8, bus8.mem_addr, bus8.in_ready); end
    send_word(0, 32'h0010_0073);
    idle(0, 1);
    wait_done8(ok);
    checks++;
    if (!ok || wr8.size() !== 1) begin fails++;
      $display("FAIL reload_writes got done=%b n=%0d want 1 1", ok, wr8.size()); end
    else begin
      checks++;
      if (wr8[0] !== {8'd0, 32'h0010_0073}) begin fails++;
        $display("FAIL reload_w0 got %h want 0000100073", wr8[0]); end
    end
    checks++;
    if (wl8 !== 9'd1 || cpu_reset8 !== 1'b0) begin fails++;
      $display("FAIL reload_final got n=%0d rst=%b want 1 0", wl8, cpu_reset8); end
  endtask

  task automatic test_mid_word_reset();
    bit ok;
    do_reset();
    send_byte(0, 8'h93);
    send_byte(0, 8'h00);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wr8.delete();
    send_word(0, 32'h0050_0093);
    send_word(0, 32'h0030_0113);
    send_word(0, 32'h0010_0073);
    idle(0, 1);
    wait_done8(ok);
    checks++;
    if (!ok || wr8.size() !== 3) begin fails++;
      $display("FAIL midrst_writes got done=%b n=%0d want 1 3", ok, wr8.size()); end
    else begin
      checks++;
      if (wr8[0] !== {8'd0, 32'h0050_0093}) begin fails++;
        $display("FAIL midrst_w0 got %h want 0000500093", wr8[0]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] words [4];
    words = '{32'h0000_0013, 32'h0010_0093,
              32'h0020_0113, 32'h0030_0193};
    do_reset();
    for (int i = 0; i < 4; i++) send_word(1, words[i]);
    idle(1, 4);
    checks++;
    if (wr2.size() !== 4) begin fails++;
      $display("FAIL ovf_nwrites got %0d want 4", wr2.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr2[i] !== {8'(i), words[i]}) begin fails++;
          $display("FAIL ovf_w%0d got %h want %h", i, wr2[i], {8'(i), words[i]}); end
      end
    end
    checks++;
    if (error2 !== 1'b1 || cpu_reset2 !== 1'b1 || done2 !== 1'b0) begin fails++;
      $display("FAIL ovf_flags got err=%b rst=%b done=%b want 1 1 0",
               error2, cpu_reset2, done2); end
    checks++;
    if (wl2 !== 3'd4 || bus2.in_ready !== 1'b0) begin fails++;
      $display("FAIL ovf_state got n=%0d rdy=%b want 4 0", wl2, bus2.in_ready); end
    bus2.in_valid = 1'b1;
    bus2.in_data = 8'h73;
    repeat (10) @(negedge clk);
    bus2.in_valid = 1'b0;
    checks++;
    if (wr2.size() !== 4 || bus2.in_ready !== 1'b0 || error2 !== 1'b1) begin fails++;
      $display("FAIL ovf_fifth got n=%0d rdy=%b err=%b want 4 0 1",
               wr2.size(), bus2.in_ready, error2); end
    checks++;
    if (timeouts !== 0) begin fails++;
      $display("FAIL stream_stalls got %0d want 0", timeouts); end
  endtask

  initial begin
    bus8.in_valid = 1'b0;
    bus8.in_data = 8'h00;
    bus2.in_valid = 1'b0;
    bus2.in_data = 8'h00;
    test_reset();
    test_basic_load();
    test_back_pressure();
    test_ignored_reload();
    test_reload();
    test_mid_word_reset();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
